// File: rtl/decoder_pkg.sv
// Shared decode-mode encodings and constants for the select decoder pipeline.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_INVHOT = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/decode_core.sv
// Combinational select decoder: one-hot, thermometer, inverted one-hot, reserved flag.
// Latency: none (pure combinational).
// Backpressure: none; the enclosing pipeline owns all flow control.
module decode_core
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 5,
    parameter int ZERO_MASK = 1
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [1:0]            mode,
    output logic [(2**SEL_W)-1:0] vec,
    output logic                  err
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
        // Shifting out the top bit wraps to all-ones after the subtract, so sel=max works.
        therm       = (onehot << 1) - ONE;
        vec         = '0;
        err         = 1'b0;
        case (mode_e'(mode))
            MODE_ONEHOT: vec = onehot;
            MODE_THERM:  vec = therm;
            MODE_INVHOT: vec = ~onehot;
            default:     err = 1'b1;
        endcase
        if (ZERO_MASK != 0 && sel == '0) begin
            vec = '0;
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// Decoder pipeline: decode on input, one output register plus one skid register.
// Latency: 1 cycle from input transfer to out_valid when the output stage is free.
// Backpressure: in_ready is registered and drops only while the skid entry is held.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 5,
    parameter int OUT_W     = 2**SEL_W,
    parameter int ZERO_MASK = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vec,
    output logic             out_err,
    output logic [15:0]      dec_count
);

    logic [OUT_W-1:0] dec_vec;
    logic             dec_err;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_vec;
    logic             skid_err;
    logic             in_xfer;
    logic             out_xfer;

    decode_core #(
        .SEL_W     (SEL_W),
        .ZERO_MASK (ZERO_MASK)
    ) u_core (
        .sel  (in_sel),
        .mode (in_mode),
        .vec  (dec_vec),
        .err  (dec_err)
    );

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_vec    <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_vec   <= '0;
            skid_err   <= 1'b0;
            dec_count  <= '0;
        end else begin
            if (skid_valid) begin
                // in_ready is low here, so only a drain can change state.
                if (out_xfer) begin
                    out_vec    <= skid_vec;
                    out_err    <= skid_err;
                    skid_valid <= 1'b0;
                    in_ready   <= 1'b1;
                end else begin
                    in_ready   <= 1'b0;
                end
            end else if (in_xfer) begin
                if (!out_valid || out_xfer) begin
                    out_valid <= 1'b1;
                    out_vec   <= dec_vec;
                    out_err   <= dec_err;
                    in_ready  <= 1'b1;
                end else begin
                    skid_valid <= 1'b1;
                    skid_vec   <= dec_vec;
                    skid_err   <= dec_err;
                    in_ready   <= 1'b0;
                end
            end else begin
                in_ready <= 1'b1;
                if (out_xfer) begin
                    out_valid <= 1'b0;
                end
            end

            if (out_xfer && dec_count != COUNT_MAX) begin
                dec_count <= dec_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: queue-based reference model, per-cycle compare, directed literals.
module tb_decoder_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  in_sel = 5'd0;
    logic [1:0]  in_mode = 2'd0;

    logic        rdy0, ov0, err0, rdy1, ov1, err1;
    logic [31:0] vec0, vec1;
    logic [15:0] cnt0, cnt1;

    decoder_pipe #(.SEL_W(5), .ZERO_MASK(0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_sel(in_sel), .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready),
        .out_vec(vec0), .out_err(err0), .dec_count(cnt0)
    );

    decoder_pipe #(.SEL_W(5), .ZERO_MASK(1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_sel(in_sel), .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready),
        .out_vec(vec1), .out_err(err1), .dec_count(cnt1)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: FIFO of pending results, capacity 2.
    typedef struct packed {
        logic [31:0] v0;
        logic [31:0] v1;
        logic        e;
    } res_t;

    res_t        q[$];
    logic        armed = 1'b0;
    logic [15:0] mcount = 16'd0;
    int          delivered = 0;
    logic        ix, ox;

    function automatic logic [31:0] ref_vec(input logic [1:0] m, input logic [4:0] s, input bit zm);
        logic [63:0] oh;
        logic [31:0] r;
        oh = 64'd1 << s;
        case (m)
            2'b00:   r = oh[31:0];
            2'b01:   r = 32'((oh << 1) - 64'd1);
            2'b10:   r = ~oh[31:0];
            default: r = 32'h0;
        endcase
        if (zm && s == 5'd0) r = 32'h0;
        return r;
    endfunction

    function automatic bit exp_ready();
        return armed && (q.size() < 2);
    endfunction

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            q.delete();
            armed  = 1'b0;
            mcount = 16'd0;
        end else begin
            ix = in_valid && exp_ready();
            ox = (q.size() > 0) && out_ready;
            if (ox) begin
                void'(q.pop_front());
                delivered++;
                if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
            end
            if (ix) begin
                q.push_back('{v0: ref_vec(in_mode, in_sel, 1'b0),
                              v1: ref_vec(in_mode, in_sel, 1'b1),
                              e:  (in_mode == 2'b11)});
            end
            armed = 1'b1;
        end
    end

    initial forever begin
        @(negedge clock);
        chk1("in_ready", rdy0, exp_ready());
        chk1("in_ready_zm", rdy1, exp_ready());
        chk1("out_valid", ov0, q.size() > 0);
        chk1("out_valid_zm", ov1, q.size() > 0);
        chk("dec_count", 32'(cnt0), 32'(mcount));
        chk("dec_count_zm", 32'(cnt1), 32'(mcount));
        if (q.size() > 0) begin
            chk("out_vec", vec0, q[0].v0);
            chk("out_vec_zm", vec1, q[0].v1);
            chk1("out_err", err0, q[0].e);
            chk1("out_err_zm", err1, q[0].e);
        end
    end

    // Drive one request for one cycle starting at a negedge; returns at the next negedge.
    task automatic send(input logic [1:0] m, input logic [4:0] s);
        in_valid = 1'b1;
        in_mode  = m;
        in_sel   = s;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    int cyc;

    initial begin
        #1 reset = 1'b1;
        #1;
        chk1("rst_out_valid", ov0, 1'b0);
        chk("rst_out_vec", vec0, 32'h0);
        chk1("rst_out_err", err0, 1'b0);
        chk("rst_dec_count", 32'(cnt0), 32'h0);
        chk1("rst_in_ready", rdy0, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1 chk1("rel_in_ready_before_edge", rdy0, 1'b0);
        @(posedge clock);
        #1 chk1("rel_in_ready_after_edge", rdy0, 1'b1);
        @(negedge clock);

        out_ready = 1'b1;
        for (int s = 0; s < 32; s++) begin
            send(2'b00, 5'(s));
            chk1("sweep_valid", ov0, 1'b1);
            chk("sweep_vec", vec0, 32'h1 << s);
            if (s == 31) chk("sweep_sel31", vec0, 32'h8000_0000);
        end
        send(2'b01, 5'd4);
        chk("therm_sel4", vec0, 32'h0000_001F);
        send(2'b10, 5'd2);
        chk("invhot_sel2", vec0, 32'hFFFF_FFFB);
        send(2'b11, 5'd7);
        chk("rsvd_vec", vec0, 32'h0);
        chk1("rsvd_err", err0, 1'b1);
        send(2'b00, 5'd0);
        chk("zm_onehot_sel0", vec1, 32'h0);
        chk("nozm_onehot_sel0", vec0, 32'h1);
        send(2'b01, 5'd0);
        chk("zm_therm_sel0", vec1, 32'h0);
        chk("nozm_therm_sel0", vec0, 32'h1);
        chk1("zm_therm_err", err1, 1'b0);
        @(negedge clock);

        out_ready = 1'b0;
        send(2'b00, 5'd3);
        send(2'b00, 5'd5);
        chk1("stall_in_ready", rdy0, 1'b0);
        chk("stall_vec", vec0, 32'h8);
        repeat (2) @(negedge clock);
        chk("stall_hold_vec", vec0, 32'h8);
        chk1("stall_hold_valid", ov0, 1'b1);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("drain_second", vec0, 32'h20);
        chk1("drain_in_ready", rdy0, 1'b1);
        @(negedge clock);
        @(posedge clock);
        #1 chk1("drain_empty", ov0, 1'b0);

        @(negedge clock);
        cyc = 0;
        while (delivered < 70000 && cyc < 90000) begin
            if (cyc < 3000) begin
                in_valid  = ($urandom_range(1) == 1);
                out_ready = ($urandom_range(1) == 1);
            end else begin
                in_valid  = ($urandom_range(31) != 0);
                out_ready = ($urandom_range(31) != 0);
            end
            in_sel  = 5'($urandom);
            in_mode = 2'($urandom);
            @(negedge clock);
            cyc++;
        end
        chk1("random_budget", delivered >= 70000, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("sat_count", 32'(cnt0), 32'h0000_FFFF);
        chk("sat_count_zm", 32'(cnt1), 32'h0000_FFFF);

        out_ready = 1'b0;
        send(2'b00, 5'd1);
        send(2'b00, 5'd2);
        chk1("full_in_ready", rdy0, 1'b0);
        chk1("full_out_valid", ov0, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("midrst_out_valid", ov0, 1'b0);
        chk("midrst_count", 32'(cnt0), 32'h0);
        chk("midrst_vec", vec0, 32'h0);
        chk1("midrst_err", err0, 1'b0);
        chk1("midrst_in_ready", rdy0, 1'b0);
        chk1("midrst_out_valid_zm", ov1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk1("midrst_rel_before_edge", rdy0, 1'b0);
        @(posedge clock);
        #1;
        chk1("midrst_rel_in_ready", rdy0, 1'b1);
        chk1("midrst_rel_out_valid", ov0, 1'b0);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
